// File: rtl/lfsr_word_arbiter_if.sv
// Request/grant/word bundle between PRBS consumers and lfsr_word_arbiter.
// master = requester side, slave = arbiter side.
interface lfsr_word_arbiter_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned WORD_W = 8
);
  logic [NREQ-1:0]   req;
  logic              seed_load;
  logic [3:0]        seed;
  logic              word_ack;
  logic [NREQ-1:0]   gnt;
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic              busy;

  modport master (
    output req, seed_load, seed, word_ack,
    input  gnt, word, word_valid, busy
  );

  modport slave (
    input  req, seed_load, seed, word_ack,
    output gnt, word, word_valid, busy
  );
endinterface

// File: rtl/lfsr_word_arbiter.sv
// Round-robin arbiter sharing one 4-bit PRBS LFSR; the winner receives a WORD_W-bit word
// serialised from WORD_W LFSR steps and held until acknowledged.
module lfsr_word_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned WORD_W = 8,
  parameter logic [3:0]  SEED   = 4'h1
) (
  input logic                 clk,
  input logic                 rst_n,
  lfsr_word_arbiter_if.slave  bus
);

  localparam int unsigned PtrW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW    = $clog2(WORD_W + 1);
  localparam logic [3:0]  SeedEff = (SEED == 4'h0) ? 4'h1 : SEED;

  typedef enum logic [1:0] {StIdle, StGen, StHold} state_e;

  state_e            state_q, state_d;
  logic [3:0]        lfsr_q, lfsr_d, lfsr_nxt;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [PtrW-1:0]   win_q, win_d;
  logic [PtrW-1:0]   rr_win, rr_cand;
  logic              rr_found;

  assign lfsr_nxt = {lfsr_q[2], lfsr_q[1], lfsr_q[0] ^ lfsr_q[3], lfsr_q[3]};

  // First set request at or after the pointer, wrapping.
  always_comb begin
    rr_win   = ptr_q;
    rr_found = 1'b0;
    rr_cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rr_cand = PtrW'((32'(ptr_q) + i) % NREQ);
      if (!rr_found && bus.req[rr_cand]) begin
        rr_found = 1'b1;
        rr_win   = rr_cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    gnt_d   = gnt_q;
    word_d  = word_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    unique case (state_q)
      StIdle: begin
        if (bus.seed_load) begin
          lfsr_d = (bus.seed == 4'h0) ? 4'h1 : bus.seed;
        end else if (|bus.req) begin
          gnt_d         = '0;
          gnt_d[rr_win] = 1'b1;
          win_d         = rr_win;
          cnt_d         = '0;
          state_d       = StGen;
        end
      end
      StGen: begin
        // WORD_W shifting cycles, then one more to raise valid.
        if (cnt_q == CntW'(WORD_W)) begin
          valid_d = 1'b1;
          state_d = StHold;
        end else begin
          word_d = {word_q[WORD_W-2:0], lfsr_q[0]};
          lfsr_d = lfsr_nxt;
          cnt_d  = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        if (bus.word_ack) begin
          valid_d = 1'b0;
          gnt_d   = '0;
          ptr_d   = (win_q == PtrW'(NREQ - 1)) ? '0 : win_q + PtrW'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lfsr_q  <= SeedEff;
      gnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      gnt_q   <= gnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.word       = word_q;
  assign bus.word_valid = valid_q;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_lfsr_word_arbiter.sv
// Scoreboard bench for lfsr_word_arbiter: predicted grant/word pushed at request time,
// popped and compared when word_valid rises.
module tb_lfsr_word_arbiter;
  localparam int unsigned NREQ   = 4;
  localparam int unsigned WORD_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lfsr_word_arbiter_if #(.NREQ(NREQ), .WORD_W(WORD_W)) bus ();

  lfsr_word_arbiter #(.NREQ(NREQ), .WORD_W(WORD_W), .SEED(4'h1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [NREQ-1:0]   gnt;
    logic [WORD_W-1:0] word;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_bad = 0;
  logic [3:0]  m_lfsr;
  int unsigned m_ptr;
  int unsigned m_win;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, 32'(bus.gnt), 32'h0);
    check({tag, "_word"}, 32'(bus.word), 32'h0);
    check({tag, "_valid"}, 32'(bus.word_valid), 32'h0);
    check({tag, "_busy"}, 32'(bus.busy), 32'h0);
  endtask

  task automatic do_reset();
    bus.req       = '0;
    bus.seed_load = 1'b0;
    bus.seed      = 4'h0;
    bus.word_ack  = 1'b0;
    rst_n         = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n  = 1'b1;
    m_lfsr = 4'h1;
    m_ptr  = 0;
    sb_q.delete();
  endtask

  // Model: round-robin winner from the pointer, then WORD_W LFSR bits, first bit at the MSB.
  task automatic predict(input logic [NREQ-1:0] mask);
    exp_t        e;
    bit          found;
    int unsigned idx;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (m_ptr + i) % NREQ;
      if (!found && mask[idx]) begin
        found = 1'b1;
        m_win = idx;
      end
    end
    e.gnt        = '0;
    e.gnt[m_win] = 1'b1;
    e.word       = '0;
    for (int i = 0; i < WORD_W; i++) begin
      e.word = {e.word[WORD_W-2:0], m_lfsr[0]};
      m_lfsr = {m_lfsr[2], m_lfsr[1], m_lfsr[0] ^ m_lfsr[3], m_lfsr[3]};
    end
    sb_q.push_back(e);
  endtask

  task automatic run_word(input logic [NREQ-1:0] mask, input int ack_delay, input bit drop_req,
                          input bit noise, output logic [WORD_W-1:0] got_word,
                          output logic [NREQ-1:0] got_gnt);
    exp_t e;
    int   cyc;
    predict(mask);
    bus.req = mask;
    tick();
    check("gnt_at_grant", 32'(bus.gnt), 32'(sb_q[0].gnt));
    check("busy_at_grant", 32'(bus.busy), 32'h1);
    if (drop_req) bus.req = '0;
    cyc = 0;
    while (!bus.word_valid && cyc < 40) begin
      if (noise && cyc == 3) begin
        bus.seed_load = 1'b1;
        bus.seed      = 4'h3;
        bus.word_ack  = 1'b1;
      end else begin
        bus.seed_load = 1'b0;
        bus.word_ack  = 1'b0;
      end
      tick();
      cyc++;
      if (!bus.word_valid) check("gnt_gen", 32'(bus.gnt), 32'(sb_q[0].gnt));
    end
    bus.seed_load = 1'b0;
    bus.word_ack  = 1'b0;
    check("valid_latency", 32'(cyc), 32'(WORD_W + 1));
    e = sb_q.pop_front();
    check("word", 32'(bus.word), 32'(e.word));
    check("gnt_hold", 32'(bus.gnt), 32'(e.gnt));
    got_word = bus.word;
    got_gnt  = bus.gnt;
    for (int i = 0; i < ack_delay; i++) begin
      tick();
      check("valid_wait", 32'(bus.word_valid), 32'h1);
      check("word_wait", 32'(bus.word), 32'(e.word));
    end
    bus.word_ack = 1'b1;
    tick();
    bus.word_ack = 1'b0;
    check("idle_after_ack", 32'(bus.busy), 32'h0);
    check("gnt_after_ack", 32'(bus.gnt), 32'h0);
    check("valid_after_ack", 32'(bus.word_valid), 32'h0);
    m_ptr = (m_win + 1) % NREQ;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WORD_W-1:0] w;
    logic [NREQ-1:0]   g;
    logic [3:0]        rr_exp [5];
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Single requester, consecutive words from the reset seed.
    do_reset();
    run_word(4'b0001, 0, 1'b0, 1'b0, w, g);
    check("t1_word0", 32'(w), 32'h89);
    run_word(4'b0001, 0, 1'b0, 1'b0, w, g);
    check("t1_word1", 32'(w), 32'hAF);
    run_word(4'b0001, 0, 1'b0, 1'b0, w, g);
    check("t1_word2_from_lfsr2", 32'(w), 32'h13);
    bus.req = '0;

    // All requesters active: grants rotate.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_word(4'b1111, 0, 1'b0, 1'b0, w, g);
      check("t2_rr", 32'(g), 32'(rr_exp[i]));
    end
    bus.req = '0;

    // Zero seed maps to 1.
    do_reset();
    run_word(4'b0001, 0, 1'b0, 1'b0, w, g);
    bus.req       = '0;
    bus.seed_load = 1'b1;
    bus.seed      = 4'h0;
    tick();
    bus.seed_load = 1'b0;
    check("t3_idle_after_seed", 32'(bus.busy), 32'h0);
    m_lfsr = 4'h1;
    run_word(4'b0100, 0, 1'b0, 1'b0, w, g);
    check("t3_word", 32'(w), 32'h89);
    check("t3_gnt", 32'(g), 32'b0100);
    bus.req = '0;

    // Seed load and request together: seed wins, grant one cycle later; GEN noise ignored.
    bus.seed_load = 1'b1;
    bus.seed      = 4'hB;
    bus.req       = 4'b0010;
    tick();
    bus.seed_load = 1'b0;
    check("t4_no_gnt", 32'(bus.gnt), 32'h0);
    check("t4_not_busy", 32'(bus.busy), 32'h0);
    m_lfsr = 4'hB;
    run_word(4'b0010, 0, 1'b0, 1'b1, w, g);
    check("t4_gnt", 32'(g), 32'b0010);
    bus.req = '0;

    // Request dropped after grant, late acknowledge.
    run_word(4'b1000, 5, 1'b1, 1'b0, w, g);
    check("t5_gnt", 32'(g), 32'b1000);

    // Reset in the middle of GEN.
    do_reset();
    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    check("t6_gnt", 32'(bus.gnt), 32'b0001);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    check_reset_outputs("t6_midgen");
    rst_n  = 1'b1;
    m_lfsr = 4'h1;
    m_ptr  = 0;
    run_word(4'b0001, 0, 1'b0, 1'b0, w, g);
    check("t6_word", 32'(w), 32'h89);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
